cpu_debug_ocimem_ctrl: RTL and testbench

Debug-side on-chip memory controller sitting directly downstream of the CPU debug slave wrapper's system-clock half. Consumes its `jdo` bus and `take_action_ocimem_*` strobes to set the monitor address, read and write a small debug RAM, and return read data on `MonDReg`, which loops back to the debug slave for shift-out. A CPU-side Avalon-MM slave port shares the same RAM, and JTAG-originated operations always take priority over CPU accesses.

---
 rtl/cpu_debug_ocimem_ctrl_pkg.sv | 35 +++
 rtl/cpu_debug_ocimem_ram.sv | 23 ++
 rtl/cpu_debug_ocimem_ctrl.sv | 149 ++++++++++++++
 tb/tb_cpu_debug_ocimem_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_debug_ocimem_ctrl_pkg.sv
// rtl/cpu_debug_ocimem_ctrl_pkg.sv - shared types and jdo field positions for the debug on-chip memory controller
package cpu_debug_ocimem_ctrl_pkg;

    localparam int JDO_W        = 38;
    localparam int JDO_DATA_LSB = 3;
    localparam int JDO_DATA_MSB = 34;
    localparam int JDO_RD_NOW   = 35;
    localparam int JDO_CLR_OVR  = 34;
    localparam int JDO_ADDR_LSB = 17;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ISSUE,
        ST_RD_CAPTURE,
        ST_WR,
        ST_CPU_RD,
        ST_CPU_WR
    } ocimem_state_e;

    typedef enum logic [1:0] {
        STB_NONE,
        STB_A,
        STB_NA,
        STB_B
    } strobe_e;

    // Same-cycle strobes collapse to the highest-priority one: b > a > no_action_a.
    function automatic strobe_e strobe_encode(input logic b, input logic a, input logic na);
        if (b)       return STB_B;
        else if (a)  return STB_A;
        else if (na) return STB_NA;
        else         return STB_NONE;
    endfunction

endpackage

// File: rtl/cpu_debug_ocimem_ram.sv
// rtl/cpu_debug_ocimem_ram.sv - single-port synchronous-read debug RAM
// Ports: clk; we/addr/wdata write side; rdata = mem[addr] of the previous cycle.
// Contents are deliberately not reset so the array maps onto block RAM.
module cpu_debug_ocimem_ram #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/cpu_debug_ocimem_ctrl.sv
// rtl/cpu_debug_ocimem_ctrl.sv - JTAG/CPU arbitrated controller for the debug on-chip RAM
// Ports: clk, reset (sync, active-high); jdo + take_*_ocimem_* strobes from the debug slave;
// MonDReg/MonAReg/ocimem_rd_done/ocimem_overrun back to it; cpu_* Avalon-MM slave sharing the RAM.
module cpu_debug_ocimem_ctrl
    import cpu_debug_ocimem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [31:0]       MonDReg,
    output logic [ADDR_W-1:0] MonAReg,
    output logic              ocimem_rd_done,
    output logic              ocimem_overrun,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [31:0]       cpu_writedata,
    output logic [31:0]       cpu_readdata,
    output logic              cpu_waitrequest
);

    ocimem_state_e     state, state_nxt;
    strobe_e           in_code, cmd_code, pend_code;
    logic              pend_valid;
    logic [JDO_W-1:0]  pend_jdo, cmd_jdo;
    logic              cpu_rd_done;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata, ram_rdata;
    logic              unused_jdo;

    assign in_code  = strobe_encode(take_action_ocimem_b, take_action_ocimem_a, take_no_action_ocimem_a);
    // A held strobe is always served ahead of whatever arrives in the same IDLE cycle.
    assign cmd_code = pend_valid ? pend_code : in_code;
    assign cmd_jdo  = pend_valid ? pend_jdo : jdo;
    assign unused_jdo = ^{cmd_jdo[JDO_W-1:JDO_RD_NOW+1], cmd_jdo[JDO_DATA_LSB-1:0]};

    // cpu_rd_done marks the IDLE cycle in which a finished CPU read is handed back.
    assign cpu_waitrequest = (cpu_read | cpu_write) & ~((state == ST_CPU_WR) | cpu_rd_done);

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ram_we    = 1'b0;
        ram_addr  = cpu_address;
        ram_wdata = cpu_writedata;
        case (state)
            ST_IDLE: begin
                if (cmd_code == STB_B) begin
                    state_nxt = ST_WR;
                end else if (cmd_code == STB_NA || (cmd_code == STB_A && cmd_jdo[JDO_RD_NOW])) begin
                    state_nxt = ST_RD_ISSUE;
                end else if (cmd_code == STB_A) begin
                    state_nxt = ST_IDLE;
                end else if (!cpu_rd_done && cpu_read) begin
                    state_nxt = ST_CPU_RD;
                end else if (!cpu_rd_done && cpu_write) begin
                    state_nxt = ST_CPU_WR;
                end
            end
            ST_RD_ISSUE: begin
                ram_addr  = MonAReg;
                state_nxt = ST_RD_CAPTURE;
            end
            ST_RD_CAPTURE: state_nxt = ST_IDLE;
            ST_WR: begin
                ram_addr  = MonAReg;
                ram_wdata = MonDReg;
                ram_we    = ~reset;
                state_nxt = ST_IDLE;
            end
            ST_CPU_RD: state_nxt = ST_IDLE;
            ST_CPU_WR: begin
                ram_we    = ~reset;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            MonDReg        <= '0;
            MonAReg        <= '0;
            ocimem_rd_done <= 1'b0;
            ocimem_overrun <= 1'b0;
            cpu_readdata   <= '0;
            cpu_rd_done    <= 1'b0;
            pend_valid     <= 1'b0;
            pend_code      <= STB_NONE;
            pend_jdo       <= '0;
        end else begin
            ocimem_rd_done <= 1'b0;
            cpu_rd_done    <= (state == ST_CPU_RD);
            if (state == ST_IDLE) begin
                // Draining the pending slot frees it for a strobe arriving this cycle.
                if (pend_valid) begin
                    pend_valid <= (in_code != STB_NONE);
                    pend_code  <= in_code;
                    pend_jdo   <= jdo;
                end
                case (cmd_code)
                    STB_B: MonDReg <= cmd_jdo[JDO_DATA_MSB:JDO_DATA_LSB];
                    STB_A: begin
                        MonAReg <= cmd_jdo[JDO_ADDR_LSB +: ADDR_W];
                        if (cmd_jdo[JDO_CLR_OVR]) ocimem_overrun <= 1'b0;
                    end
                    default: ;
                endcase
            end else if (in_code != STB_NONE) begin
                if (pend_valid) begin
                    ocimem_overrun <= 1'b1;
                end else begin
                    pend_valid <= 1'b1;
                    pend_code  <= in_code;
                    pend_jdo   <= jdo;
                end
            end
            case (state)
                ST_RD_CAPTURE: begin
                    MonDReg        <= ram_rdata;
                    MonAReg        <= MonAReg + ADDR_W'(1);
                    ocimem_rd_done <= 1'b1;
                end
                ST_WR:     MonAReg      <= MonAReg + ADDR_W'(1);
                ST_CPU_RD: cpu_readdata <= ram_rdata;
                default: ;
            endcase
        end
    end

    cpu_debug_ocimem_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_cpu_debug_ocimem_ctrl.sv
// tb/tb_cpu_debug_ocimem_ctrl.sv - directed self-checking bench for cpu_debug_ocimem_ctrl
module tb_cpu_debug_ocimem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
    logic [31:0] MonDReg;
    logic [7:0]  MonAReg;
    logic        ocimem_rd_done, ocimem_overrun;
    logic [7:0]  cpu_address;
    logic        cpu_read, cpu_write;
    logic [31:0] cpu_writedata, cpu_readdata;
    logic        cpu_waitrequest;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cpu_debug_ocimem_ctrl #(.ADDR_W(8)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .MonDReg                 (MonDReg),
        .MonAReg                 (MonAReg),
        .ocimem_rd_done          (ocimem_rd_done),
        .ocimem_overrun          (ocimem_overrun),
        .cpu_address             (cpu_address),
        .cpu_read                (cpu_read),
        .cpu_write               (cpu_write),
        .cpu_writedata           (cpu_writedata),
        .cpu_readdata            (cpu_readdata),
        .cpu_waitrequest         (cpu_waitrequest)
    );

    function automatic logic [37:0] jdo_a(input logic [7:0] addr, input logic rd, input logic clr);
        logic [37:0] j;
        j = '0;
        j[24:17] = addr;
        j[35] = rd;
        j[34] = clr;
        return j;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] data);
        logic [37:0] j;
        j = '0;
        j[34:3] = data;
        return j;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_a(input logic [7:0] addr, input logic rd, input logic clr);
        jdo = jdo_a(addr, rd, clr);
        take_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
    endtask

    task automatic pulse_b(input logic [31:0] data);
        jdo = jdo_b(data);
        take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        jdo = '0;
        take_action_ocimem_a = 0; take_no_action_ocimem_a = 0; take_action_ocimem_b = 0;
        cpu_address = '0; cpu_read = 0; cpu_write = 0; cpu_writedata = '0;
        repeat (3) tick();
        checks++;
        if ({MonDReg, MonAReg, ocimem_rd_done, ocimem_overrun, cpu_readdata, cpu_waitrequest} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: MonDReg=%h MonAReg=%h rd_done=%b ovr=%b rdata=%h wait=%b, required all 0",
                     MonDReg, MonAReg, ocimem_rd_done, ocimem_overrun, cpu_readdata, cpu_waitrequest);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_write();
        pulse_a(8'h10, 1'b0, 1'b0);
        checks++;
        if (MonAReg !== 8'h10) begin failures++; $display("FAIL addr_load: MonAReg=%h required 10", MonAReg); end
        pulse_b(32'hDEADBEEF);
        checks++;
        if (MonDReg !== 32'hDEADBEEF || MonAReg !== 8'h10) begin
            failures++; $display("FAIL wr_mondreg: MonDReg=%h MonAReg=%h required deadbeef/10", MonDReg, MonAReg);
        end
        tick();
        checks++;
        if (MonAReg !== 8'h11 || dut.u_ram.mem[8'h10] !== 32'hDEADBEEF) begin
            failures++; $display("FAIL wr_ram: MonAReg=%h mem=%h required 11/deadbeef", MonAReg, dut.u_ram.mem[8'h10]);
        end
        pulse_b(32'h0BADF00D);
        tick();
        checks++;
        if (MonAReg !== 8'h12 || dut.u_ram.mem[8'h11] !== 32'h0BADF00D) begin
            failures++; $display("FAIL wr2_ram: MonAReg=%h mem=%h required 12/0badf00d", MonAReg, dut.u_ram.mem[8'h11]);
        end
    endtask

    task automatic test_read();
        jdo = jdo_a(8'h10, 1'b1, 1'b0);
        take_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
        tick();
        checks++;
        if (ocimem_rd_done !== 1'b0 || MonAReg !== 8'h10) begin
            failures++; $display("FAIL rd_early: rd_done=%b MonAReg=%h required 0/10", ocimem_rd_done, MonAReg);
        end
        tick();
        checks++;
        if (ocimem_rd_done !== 1'b1 || MonDReg !== 32'hDEADBEEF || MonAReg !== 8'h11) begin
            failures++; $display("FAIL rd_done: rd_done=%b MonDReg=%h MonAReg=%h required 1/deadbeef/11",
                                 ocimem_rd_done, MonDReg, MonAReg);
        end
        tick();
        checks++;
        if (ocimem_rd_done !== 1'b0) begin failures++; $display("FAIL rd_done_pulse: rd_done=%b required 0", ocimem_rd_done); end
    endtask

    task automatic test_wrap();
        pulse_a(8'hFF, 1'b0, 1'b0);
        pulse_b(32'h1);
        tick();
        checks++;
        if (MonAReg !== 8'h00 || dut.u_ram.mem[8'hFF] !== 32'h1) begin
            failures++; $display("FAIL wrap: MonAReg=%h mem=%h required 00/1", MonAReg, dut.u_ram.mem[8'hFF]);
        end
    endtask

    task automatic test_cpu_access();
        cpu_address = 8'h30; cpu_writedata = 32'hA5A50001; cpu_write = 1'b1;
        #1;
        checks++;
        if (cpu_waitrequest !== 1'b1) begin failures++; $display("FAIL cpu_wr_wait0: wait=%b required 1", cpu_waitrequest); end
        tick();
        checks++;
        if (cpu_waitrequest !== 1'b0) begin failures++; $display("FAIL cpu_wr_wait1: wait=%b required 0", cpu_waitrequest); end
        cpu_write = 1'b0;
        tick();
        checks++;
        if (dut.u_ram.mem[8'h30] !== 32'hA5A50001) begin
            failures++; $display("FAIL cpu_wr_ram: mem=%h required a5a50001", dut.u_ram.mem[8'h30]);
        end
        cpu_read = 1'b1;
        #1;
        checks++;
        if (cpu_waitrequest !== 1'b1) begin failures++; $display("FAIL cpu_rd_wait0: wait=%b required 1", cpu_waitrequest); end
        tick();
        checks++;
        if (cpu_waitrequest !== 1'b1) begin failures++; $display("FAIL cpu_rd_wait1: wait=%b required 1", cpu_waitrequest); end
        tick();
        checks++;
        if (cpu_waitrequest !== 1'b0 || cpu_readdata !== 32'hA5A50001) begin
            failures++; $display("FAIL cpu_rd_data: wait=%b rdata=%h required 0/a5a50001", cpu_waitrequest, cpu_readdata);
        end
        cpu_read = 1'b0;
        tick();
        checks++;
        if (cpu_waitrequest !== 1'b0) begin failures++; $display("FAIL cpu_idle_wait: wait=%b required 0", cpu_waitrequest); end
    endtask

    task automatic test_contention();
        int lat;
        pulse_a(8'h10, 1'b0, 1'b0);
        take_no_action_ocimem_a = 1'b1;
        cpu_address = 8'h10; cpu_read = 1'b1;
        #1;
        checks++;
        if (cpu_waitrequest !== 1'b1) begin failures++; $display("FAIL cont_wait0: wait=%b required 1", cpu_waitrequest); end
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            take_no_action_ocimem_a = 1'b0;
            if (k == 3) begin
                checks++;
                if (ocimem_rd_done !== 1'b1 || MonDReg !== 32'hDEADBEEF || cpu_waitrequest !== 1'b1) begin
                    failures++; $display("FAIL cont_jtag_first: rd_done=%b MonDReg=%h wait=%b required 1/deadbeef/1",
                                         ocimem_rd_done, MonDReg, cpu_waitrequest);
                end
            end
            if (cpu_waitrequest === 1'b0) begin
                lat = k;
                break;
            end
        end
        checks++;
        if (lat !== 5 || cpu_readdata !== 32'hDEADBEEF) begin
            failures++; $display("FAIL cont_cpu: latency=%0d rdata=%h required 5/deadbeef (0 = timeout)", lat, cpu_readdata);
        end
        cpu_read = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        jdo = jdo_a(8'h10, 1'b1, 1'b0);
        take_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
        take_no_action_ocimem_a = 1'b1;
        tick();
        tick();
        take_no_action_ocimem_a = 1'b0;
        checks++;
        if (ocimem_overrun !== 1'b1 || ocimem_rd_done !== 1'b1 || MonDReg !== 32'hDEADBEEF) begin
            failures++; $display("FAIL ovr_set: ovr=%b rd_done=%b MonDReg=%h required 1/1/deadbeef",
                                 ocimem_overrun, ocimem_rd_done, MonDReg);
        end
        repeat (3) tick();
        checks++;
        if (ocimem_rd_done !== 1'b1 || MonDReg !== 32'h0BADF00D || MonAReg !== 8'h12) begin
            failures++; $display("FAIL pend_read: rd_done=%b MonDReg=%h MonAReg=%h required 1/0badf00d/12",
                                 ocimem_rd_done, MonDReg, MonAReg);
        end
        repeat (4) tick();
        checks++;
        if (MonAReg !== 8'h12 || ocimem_overrun !== 1'b1) begin
            failures++; $display("FAIL dropped: MonAReg=%h ovr=%b required 12/1", MonAReg, ocimem_overrun);
        end
        pulse_a(8'h00, 1'b0, 1'b1);
        checks++;
        if (ocimem_overrun !== 1'b0 || MonAReg !== 8'h00) begin
            failures++; $display("FAIL ovr_clear: ovr=%b MonAReg=%h required 0/00", ocimem_overrun, MonAReg);
        end
        // a and b together: b wins; the address field embedded in the data must not load.
        jdo = jdo_b(32'h00100077);
        take_action_ocimem_a = 1'b1;
        take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        tick();
        checks++;
        if (MonAReg !== 8'h01 || dut.u_ram.mem[8'h00] !== 32'h00100077 || ocimem_overrun !== 1'b0) begin
            failures++; $display("FAIL priority: MonAReg=%h mem=%h ovr=%b required 01/00100077/0",
                                 MonAReg, dut.u_ram.mem[8'h00], ocimem_overrun);
        end
    endtask

    task automatic test_reset_during_wr();
        pulse_a(8'h20, 1'b0, 1'b0);
        pulse_b(32'hCAFEF00D);
        tick();
        pulse_a(8'h20, 1'b0, 1'b0);
        pulse_b(32'h55);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (dut.u_ram.mem[8'h20] !== 32'hCAFEF00D) begin
            failures++; $display("FAIL rst_wr_ram: mem=%h required cafef00d", dut.u_ram.mem[8'h20]);
        end
        checks++;
        if ({MonDReg, MonAReg, ocimem_rd_done, ocimem_overrun, cpu_readdata, cpu_waitrequest} !== '0) begin
            failures++; $display("FAIL rst_wr_outputs: MonDReg=%h MonAReg=%h rd_done=%b ovr=%b rdata=%h wait=%b, required all 0",
                                 MonDReg, MonAReg, ocimem_rd_done, ocimem_overrun, cpu_readdata, cpu_waitrequest);
        end
        tick();
        checks++;
        if (MonAReg !== 8'h00) begin failures++; $display("FAIL rst_wr_noinc: MonAReg=%h required 00", MonAReg); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_wrap();
        test_cpu_access();
        test_contention();
        test_back_to_back();
        test_reset_during_wr();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
